hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RISC-V core, sitting beside the decode stage and its ID/EX register. It keeps its own shadow pipeline of destination-register information for the EX, MEM and WB stages. From that state it drives stall, flush and forwarding selects for the fetch/decode/execute datapath. It resolves load-use hazards, taken-branch redirection, EX-stage operand forwarding and WB-to-ID register-file bypass.

Parameters:
REG_W, 5, register-index width (32 architectural registers; x0 hard-wired zero)

Ports:
clk  in  1  core clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
Rs1D  in  REG_W  rs1 index of instruction in decode (InstrDe[19:15])
Rs2D  in  REG_W  rs2 index of instruction in decode (InstrDe[24:20])
RdD  in  REG_W  rd index of instruction in decode (InstrDe[11:7])
RegWrtD  in  1  decode instruction writes rd
ResultSrcD  in  1  decode instruction is a load (result from memory)
PCSrcE  in  1  branch in EX is taken this cycle
StallF  out  1  hold PC register
StallD  out  1  hold IF/ID register
FlushD  out  1  clear IF/ID register (insert NOP)
FlushE  out  1  clear ID/EX register (insert bubble)
ForwardAE  out  2  EX operand A select: 00 regfile, 10 ALU result in MEM, 01 ResultW
ForwardBE  out  2  EX operand B select, same encoding
BypassAD  out  1  decode RD1 takes ResultW instead of regfile
BypassBD  out  1  decode RD2 takes ResultW instead of regfile

Behaviour:
- Internal state: shadow entries E, M, W, each {vld, wr, ld, rd}; plus Rs1E/Rs2E captured from decode.
- Reset (rst=0, async): all entries vld=0, wr=0, ld=0, rd=0; Rs1E=Rs2E=0. All outputs 0 during and after reset until valid inputs arrive.
- Match rule: index m "hits" stage S iff S.vld & S.wr & (S.rd == m) & (m != 0). x0 never hits.
- Load-use (combinational on current state): lduse = E.vld & E.ld & E.wr & (E.rd != 0) & (E.rd == Rs1D | E.rd == Rs2D).
- Branch: br = PCSrcE.
- Outputs, combinational:
  - StallF = StallD = lduse & ~br.
  - FlushD = br.
  - FlushE = br | lduse.
  - Branch has priority: a taken branch cancels the decode instruction, so no stall is raised.
- Forwarding: ForwardAE = 10 if Rs1E hits M; else 01 if Rs1E hits W; else 00. MEM has priority over WB. ForwardBE is the same rule on Rs2E.
- Bypass: BypassAD = Rs1D hits W; BypassBD = Rs2D hits W.
- Shadow advance every rising edge, no global enable:
  - W <= M.
  - M <= E.
  - E <= bubble (all zero) if FlushE; else {1, RegWrtD, ResultSrcD, RdD}.
  - Rs1E/Rs2E <= 0 if FlushE; else Rs1D/Rs2D.
- Stalls are single-cycle for a single load-use. After the bubble, the load sits in W when the consumer reaches EX, so ForwardxE=01.
- A back-to-back dependent chain never stalls more than one cycle per load.
- Mid-operation reset clears all shadow entries immediately. No stale forward selects after rst deasserts.
- Latency: all outputs are combinational from current state and inputs (0 cycles). Shadow state lags the datapath registers by nothing; it updates on the same edge as the ID/EX, EX/MEM and MEM/WB registers.

Test Plan:
1. Reset with rst=0 mid-stream, shadow previously full -> all outputs 0; after release, Rs1D=5 with no prior writer -> ForwardAE=00, BypassAD=0.
2. add x5 (RdD=5, RegWrtD=1) then next cycle Rs1E=5 -> ForwardAE=10. Following cycle, another instruction with Rs2E=5 -> ForwardBE=01.
3. lw x6 then add x7,x6,x1 -> for 1 cycle StallF=StallD=FlushE=1. Next cycle stall=0 and the add in EX gets ForwardAE=01.
4. lw x0 then add using rs1=0 -> no stall; writes to x0 never produce ForwardxE or Bypass.
5. lw x6 followed by a dependent add while PCSrcE=1 in the same cycle -> FlushD=FlushE=1, StallF=StallD=0. E shadow becomes a bubble, and next cycle M.vld=1 holds the branch only.
6. Same rd written in M and W (x9 twice), consumer Rs1E=9 -> ForwardAE=10 (MEM priority). W writes x9 while decode reads Rs2D=9 -> BypassBD=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stall, branch flush,
// EX operand forwarding and WB-to-ID bypass from a shadow rd pipeline.
module hazard_ctrl #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] RdD,
  input  logic             RegWrtD,
  input  logic             ResultSrcD,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             BypassAD,
  output logic             BypassBD
);

  typedef struct packed {
    logic             vld;
    logic             wr;
    logic             ld;
    logic [REG_W-1:0] rd;
  } shd_t;

  shd_t             e_q;
  shd_t             m_q;
  shd_t             w_q;
  shd_t             e_d;
  logic [REG_W-1:0] rs1e_q;
  logic [REG_W-1:0] rs2e_q;
  logic [REG_W-1:0] rs1e_d;
  logic [REG_W-1:0] rs2e_d;
  logic             lduse;
  logic             br;

  // x0 is hard-wired zero, so it can never be a forwarding source.
  function automatic logic hit(
    input shd_t             s,
    input logic [REG_W-1:0] m
  );
    return s.vld & s.wr & (s.rd == m) & (m != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(
    input shd_t             m,
    input shd_t             w,
    input logic [REG_W-1:0] rs
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (hit(m, rs))
      sel = 2'b10;
    else if (hit(w, rs))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    lduse = e_q.vld & e_q.ld & e_q.wr
          & (e_q.rd != '0)
          & ((e_q.rd == Rs1D) | (e_q.rd == Rs2D));
    br    = PCSrcE;
  end

  // A taken branch kills the decode instruction, so it overrides the stall.
  always_comb begin
    StallF = lduse & ~br;
    StallD = lduse & ~br;
    FlushD = br;
    FlushE = br | lduse;
  end

  always_comb begin
    ForwardAE = fwd_sel(m_q, w_q, rs1e_q);
    ForwardBE = fwd_sel(m_q, w_q, rs2e_q);
    BypassAD  = hit(w_q, Rs1D);
    BypassBD  = hit(w_q, Rs2D);
  end

  always_comb begin
    e_d    = '0;
    rs1e_d = '0;
    rs2e_d = '0;
    if (!FlushE) begin
      e_d.vld = 1'b1;
      e_d.wr  = RegWrtD;
      e_d.ld  = ResultSrcD;
      e_d.rd  = RdD;
      rs1e_d  = Rs1D;
      rs2e_d  = Rs2D;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      rs1e_q <= '0;
      rs2e_q <= '0;
    end else begin
      w_q    <= m_q;
      m_q    <= e_q;
      e_q    <= e_d;
      rs1e_q <= rs1e_d;
      rs2e_q <= rs2e_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, forwarding, load-use,
// x0, branch priority, MEM/WB priority and load chains.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] Rs1D = '0;
  logic [4:0] Rs2D = '0;
  logic [4:0] RdD = '0;
  logic       RegWrtD = 1'b0;
  logic       ResultSrcD = 1'b0;
  logic       PCSrcE = 1'b0;
  logic       StallF, StallD, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic       BypassAD, BypassBD;
  logic [9:0] obs;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .Rs1D      (Rs1D),
    .Rs2D      (Rs2D),
    .RdD       (RdD),
    .RegWrtD   (RegWrtD),
    .ResultSrcD(ResultSrcD),
    .PCSrcE    (PCSrcE),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .ForwardAE (ForwardAE),
    .ForwardBE (ForwardBE),
    .BypassAD  (BypassAD),
    .BypassBD  (BypassBD)
  );

  // {StallF,StallD,FlushD,FlushE,ForwardAE,ForwardBE,BypassAD,BypassBD}
  assign obs = {StallF, StallD, FlushD, FlushE,
                ForwardAE, ForwardBE, BypassAD, BypassBD};

  // Apply decode inputs 1 time unit after a rising edge, settle, return.
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wr,
                       input logic ld, input logic b);
    Rs1D = rs1; Rs2D = rs2; RdD = rd;
    RegWrtD = wr; ResultSrcD = ld; PCSrcE = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 5, 1, 0, 0); tick();
    drive(0, 0, 6, 1, 0, 0); tick();
    drive(0, 0, 7, 1, 0, 0); tick();
    drive(5, 6, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 10'b0) begin
      fails++;
      $display("FAIL reset_async: got %b expected %b", obs, 10'b0);
    end
    tick();
    rst = 1'b1;
    #1;
    drive(5, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0) begin
      fails++;
      $display("FAIL reset_release: got %b expected %b", obs, 10'b0);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0) begin
      fails++;
      $display("FAIL reset_no_writer: got %b expected %b", obs, 10'b0);
    end
  endtask

  task automatic test_forward();
    do_reset();
    drive(0, 0, 5, 1, 0, 0); tick();
    drive(5, 0, 8, 1, 0, 0);
    checks++;
    if (obs !== 10'b0) begin
      fails++;
      $display("FAIL fwd_decode: got %b expected %b", obs, 10'b0);
    end
    tick();
    drive(0, 5, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0000100000) begin
      fails++;
      $display("FAIL fwd_mem: got %b expected %b", obs, 10'b0000100000);
    end
    tick();
    drive(5, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0000000110) begin
      fails++;
      $display("FAIL fwd_wb_bypass: got %b expected %b", obs, 10'b0000000110);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(0, 0, 6, 1, 1, 0); tick();
    drive(6, 1, 7, 1, 0, 0);
    checks++;
    if (obs !== 10'b1101000000) begin
      fails++;
      $display("FAIL lduse_stall: got %b expected %b", obs, 10'b1101000000);
    end
    tick();
    drive(6, 1, 7, 1, 0, 0);
    checks++;
    if (obs !== 10'b0) begin
      fails++;
      $display("FAIL lduse_release: got %b expected %b", obs, 10'b0);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0000010000) begin
      fails++;
      $display("FAIL lduse_fwd_wb: got %b expected %b", obs, 10'b0000010000);
    end
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    drive(0, 0, 0, 1, 1, 0); tick();
    drive(0, 0, 3, 1, 0, 0);
    checks++;
    if (obs !== 10'b0) begin
      fails++;
      $display("FAIL x0_no_stall: got %b expected %b", obs, 10'b0);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0) begin
      fails++;
      $display("FAIL x0_no_fwd_mem: got %b expected %b", obs, 10'b0);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0) begin
      fails++;
      $display("FAIL x0_no_fwd_wb: got %b expected %b", obs, 10'b0);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    drive(0, 0, 6, 1, 1, 0); tick();
    drive(6, 0, 7, 1, 0, 1);
    checks++;
    if (obs !== 10'b0011000000) begin
      fails++;
      $display("FAIL br_priority: got %b expected %b", obs, 10'b0011000000);
    end
    tick();
    drive(6, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0) begin
      fails++;
      $display("FAIL br_bubble: got %b expected %b", obs, 10'b0);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0000010000) begin
      fails++;
      $display("FAIL br_after: got %b expected %b", obs, 10'b0000010000);
    end
    tick();
  endtask

  task automatic test_mem_priority();
    do_reset();
    drive(0, 0, 9, 1, 0, 0); tick();
    drive(0, 0, 9, 1, 0, 0); tick();
    drive(9, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0) begin
      fails++;
      $display("FAIL prio_decode: got %b expected %b", obs, 10'b0);
    end
    tick();
    drive(0, 9, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0000100001) begin
      fails++;
      $display("FAIL prio_mem: got %b expected %b", obs, 10'b0000100001);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0000000100) begin
      fails++;
      $display("FAIL prio_wb_b: got %b expected %b", obs, 10'b0000000100);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(0, 0, 6, 1, 1, 0); tick();
    drive(6, 0, 7, 1, 1, 0);
    checks++;
    if (obs !== 10'b1101000000) begin
      fails++;
      $display("FAIL b2b_stall1: got %b expected %b", obs, 10'b1101000000);
    end
    tick();
    drive(6, 0, 7, 1, 1, 0);
    checks++;
    if (obs !== 10'b0) begin
      fails++;
      $display("FAIL b2b_go1: got %b expected %b", obs, 10'b0);
    end
    tick();
    drive(7, 0, 8, 1, 0, 0);
    checks++;
    if (obs !== 10'b1101010000) begin
      fails++;
      $display("FAIL b2b_stall2: got %b expected %b", obs, 10'b1101010000);
    end
    tick();
    drive(7, 0, 8, 1, 0, 0);
    checks++;
    if (obs !== 10'b0) begin
      fails++;
      $display("FAIL b2b_go2: got %b expected %b", obs, 10'b0);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 10'b0000010000) begin
      fails++;
      $display("FAIL b2b_fwd: got %b expected %b", obs, 10'b0000010000);
    end
    tick();
  endtask

  initial begin
    #2;
    test_reset();
    test_forward();
    test_load_use();
    test_x0();
    test_branch();
    test_mem_priority();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
